// File: rtl/seq_detector_pkg.sv
// Shared constants and helper functions for the serial pattern detector.
package seq_detector_pkg;

    // Widest pattern the helper mask function can describe.
    localparam int MAX_W = 64;

    // Default configuration: detect "101" with overlapping matches.
    localparam logic [7:0] DEF_PATTERN = 8'b0000_0101;
    localparam int         DEF_LEN     = 3;

    // Bits needed to hold a length value in the range 0..w.
    function automatic int len_bits(input int w);
        return $clog2(w + 1);
    endfunction

    // Lengths of 0 or beyond the maximum mean "use the full width".
    function automatic int clamp_len(input int len, input int w);
        return ((len <= 0) || (len > w)) ? w : len;
    endfunction

    // Mask with the low `len` bits set; callers slice it to their width.
    function automatic logic [MAX_W-1:0] len_mask(input int unsigned len);
        logic [MAX_W-1:0] m;
        m = '0;
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (i < len) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;

    // Count up on inc, stick at all-ones, clear on reset or clear.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every register
        // samples the pre-edge values of its inputs.
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Serial bit-pattern detector with runtime-loadable pattern, length and
// overlap mode. Produces a same-cycle match, a held match flag and a
// saturating match count.
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int             W             = 8,
    parameter int             CNT_W         = 8,
    parameter logic [W-1:0]   RESET_PATTERN = W'(DEF_PATTERN),
    parameter int             RESET_LEN     = DEF_LEN
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    a,
    input  logic                    load,
    input  logic [W-1:0]            pattern,
    input  logic [$clog2(W+1)-1:0]  len,
    input  logic                    overlap,
    output logic                    y_mealy,
    output logic                    y_moore,
    output logic [CNT_W-1:0]        match_count
);

    localparam int LEN_W = len_bits(W);

    // History: newest bit in hist_q[0]. fill_q counts fresh bits, capped at W.
    logic [W-1:0]     hist_q, hist_d;
    logic [LEN_W-1:0] fill_q, fill_d;
    logic [W-1:0]     pat_q;
    logic [LEN_W-1:0] len_q;
    logic             ovl_q;
    logic             moore_q;

    logic [LEN_W-1:0] len_clamped;
    logic [MAX_W-1:0] mask_full;
    logic [W-1:0]     mask;
    logic [LEN_W:0]   fill_inc;
    logic             enough_bits;
    logic             match_now;

    assign len_clamped = LEN_W'(clamp_len(int'(len), W));

    // Match compare against the candidate history including the incoming bit.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        hist_d      = {hist_q[W-2:0], a};
        mask_full   = len_mask(32'(len_q));
        mask        = mask_full[W-1:0];
        fill_inc    = {1'b0, fill_q} + 1'b1;
        enough_bits = (fill_inc >= {1'b0, len_q});
        match_now   = enough_bits && (((hist_d ^ pat_q) & mask) == '0);
        // Non-overlap discards all used bits so the next match needs len fresh bits.
        if (match_now && !ovl_q) begin
            fill_d = '0;
        end else if (fill_q == LEN_W'(W)) begin
            fill_d = fill_q;
        end else begin
            fill_d = fill_q + 1'b1;
        end
    end

    // Configuration, history, fill and registered match flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= RESET_PATTERN;
            len_q   <= LEN_W'(clamp_len(RESET_LEN, W));
            ovl_q   <= 1'b1;
            moore_q <= 1'b0;
        end else if (load) begin
            // A load in the same cycle as a strobe discards that bit.
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= pattern;
            len_q   <= len_clamped;
            ovl_q   <= overlap;
            moore_q <= 1'b0;
        end else if (en) begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            moore_q <= match_now;
        end
    end

    assign y_mealy = en & match_now & ~load & ~reset;
    assign y_moore = moore_q;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .clear (load),
        .inc   (y_mealy),
        .cnt   (match_count)
    );

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector: a queue-based model of the matching
// rules checked every cycle, plus directed literal expectations.
module tb_seq_detector;

    logic       clk;
    logic       reset;
    logic       en;
    logic       a;
    logic       load;
    logic [7:0] pattern;
    logic [3:0] len;
    logic       overlap;

    logic       y_mealy,  y_moore;
    logic [7:0] match_count;
    logic       y_mealy2, y_moore2;
    logic [1:0] match_count2;

    int n_checks = 0;
    int n_fail   = 0;

    seq_detector #(.W(8), .CNT_W(8)) u_dut (
        .clk(clk), .reset(reset), .en(en), .a(a), .load(load),
        .pattern(pattern), .len(len), .overlap(overlap),
        .y_mealy(y_mealy), .y_moore(y_moore), .match_count(match_count)
    );

    seq_detector #(.W(8), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset), .en(en), .a(a), .load(load),
        .pattern(pattern), .len(len), .overlap(overlap),
        .y_mealy(y_mealy2), .y_moore(y_moore2), .match_count(match_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: bits received since the last clear, oldest first.
    bit         m_q[$];
    logic [7:0] m_pat = 8'b0000_0101;
    int         m_len = 3;
    bit         m_ovl = 1'b1;
    bit         m_moore = 1'b0;
    int         m_cnt = 0;
    int         m_cnt2 = 0;
    bit         checking = 1'b0;

    function automatic bit model_match(input bit b);
        bit tmp[$];
        tmp = m_q;
        tmp.push_back(b);
        if (tmp.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (tmp[tmp.size() - 1 - k] != m_pat[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advance the model on each clock edge from the applied inputs.
    always @(posedge clk) begin
        bit mm;
        if (reset) begin
            m_q.delete();
            m_pat = 8'b0000_0101; m_len = 3; m_ovl = 1'b1;
            m_moore = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else if (load) begin
            m_q.delete();
            m_pat = pattern;
            m_len = ((len == 0) || (len > 8)) ? 8 : int'(len);
            m_ovl = overlap;
            m_moore = 1'b0; m_cnt = 0; m_cnt2 = 0;
        end else if (en) begin
            mm = model_match(a);
            m_q.push_back(a);
            if (m_q.size() > 8) void'(m_q.pop_front());
            if (mm && !m_ovl) m_q.delete();
            m_moore = mm;
            if (mm) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
        end
    end

    // Compare both DUTs against the model every cycle, away from the edge.
    always @(negedge clk) begin
        bit exp_m;
        if (checking) begin
            exp_m = en && !load && !reset && model_match(a);
            check("y_mealy",      y_mealy,      exp_m);
            check("y_moore",      y_moore,      m_moore);
            check("match_count",  match_count,  m_cnt);
            check("y_mealy2",     y_mealy2,     exp_m);
            check("match_count2", match_count2, m_cnt2);
        end
    end

    // One cycle of stimulus: apply after the edge, return at the falling edge.
    task automatic drive(input logic r, input logic e, input logic b, input logic l);
        @(posedge clk);
        #1;
        reset = r; en = e; a = b; load = l;
        @(negedge clk);
    endtask

    task automatic strobe(input logic b, input logic exp_m, input string name);
        drive(1'b0, 1'b1, b, 1'b0);
        check(name, y_mealy, exp_m);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_load(input logic [7:0] p, input logic [3:0] ln, input logic o);
        pattern = p; len = ln; overlap = o;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [4:0] s5;
        logic [4:0] e5;
        logic [6:0] s7;
        logic [6:0] e7;

        reset = 1'b1; en = 1'b0; a = 1'b0; load = 1'b0;
        pattern = 8'h00; len = 4'd0; overlap = 1'b0;
        @(posedge clk);
        checking = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        idle();
        check("reset_moore", y_moore, 0);
        check("reset_count", match_count, 0);

        // Default pattern 101, overlapping: matches on strobes 3 and 5.
        s5 = 5'b10101; e5 = 5'b00101;
        for (int i = 4; i >= 0; i--) strobe(s5[i], e5[i], "ovl_mealy");
        idle();
        check("ovl_count", match_count, 2);
        check("ovl_moore_held", y_moore, 1);

        // Non-overlapping: match on strobe 3, then next on strobe 7.
        do_load(8'b0000_0101, 4'd3, 1'b0);
        s7 = 7'b1010101; e7 = 7'b0010001;
        for (int i = 6; i >= 2; i--) strobe(s7[i], e7[i], "novl_mealy");
        idle();
        check("novl_count_5", match_count, 1);
        for (int i = 1; i >= 0; i--) strobe(s7[i], e7[i], "novl_mealy");
        idle();
        check("novl_count_7", match_count, 2);

        // Full-width pattern: only the 8th strobe matches.
        do_load(8'b1111_0000, 4'd8, 1'b1);
        for (int i = 7; i >= 0; i--) strobe(i >= 4, i == 0, "w8_mealy");
        idle();
        check("w8_count", match_count, 1);

        // Length 0 is stored as 8: eight zeros needed for pattern 0.
        do_load(8'h00, 4'd0, 1'b1);
        for (int i = 0; i < 8; i++) strobe(1'b0, i == 7, "len0_mealy");
        idle();
        check("len0_count", match_count, 1);

        // Load with a strobe in the same cycle: the bit is discarded.
        pattern = 8'h01; len = 4'd1; overlap = 1'b1;
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("load_en_mealy", y_mealy, 0);
        idle();
        check("load_en_count", match_count, 0);
        check("load_en_moore", y_moore, 0);
        strobe(1'b1, 1'b1, "post_load_mealy");

        // Narrow counter saturates at 3; the wide one keeps counting.
        do_load(8'h01, 4'd1, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            strobe(1'b1, 1'b1, "sat_mealy");
            idle();
            check("sat_count2", match_count2, (i > 3) ? 3 : i);
            check("sat_count8", match_count, i);
        end

        // Reset after two bits of 101 loses the partial match.
        do_load(8'b0000_0101, 4'd3, 1'b1);
        strobe(1'b1, 1'b0, "rst_mid_mealy");
        strobe(1'b0, 1'b0, "rst_mid_mealy");
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, "rst_after_mealy");
        check("rst_after_count", match_count, 0);
        strobe(1'b1, 1'b0, "rst_seq_mealy");
        strobe(1'b0, 1'b0, "rst_seq_mealy");
        strobe(1'b1, 1'b1, "rst_seq_mealy");
        idle();
        check("rst_seq_count", match_count, 1);

        idle();
        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_detector.md
# seq_detector

Parametrised serial bit-pattern detector: the generalised successor of the fixed-pattern Moore/Mealy lab FSMs. It samples one serial bit per enable strobe and compares the last `len` bits against a runtime-loadable pattern. Overlapping and non-overlapping modes are supported. It produces a Mealy-style (same-cycle) and a Moore-style (registered) match output, plus a saturating match counter. It sits between the strobe-driven shift/debounce logic and the seven-segment display path.

## Interface

Parameters:
- `W`, default 8: maximum pattern length in bits, ≥ 2.
- `CNT_W`, default 8: match counter width.
- `RESET_PATTERN`, default 8'b0000_0101: pattern loaded at reset.
- `RESET_LEN`, default 3: pattern length loaded at reset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `en`  in  1: sample strobe; `a` is consumed only when high.
- `a`  in  1: serial data bit.
- `load`  in  1: latch `pattern`, `len` and `overlap`, then clear history and counter.
- `pattern`  in  W: new pattern. `pattern[0]` is the most recent bit expected.
- `len`  in  $clog2(W+1): new pattern length.
- `overlap`  in  1: 1 = overlapping matches, 0 = non-overlapping.
- `y_mealy`  out  1: combinational match indication for the current strobe.
- `y_moore`  out  1: registered match flag, held between strobes.
- `match_count`  out  CNT_W: saturating count of matches.

## Operation

- Internal state:
  - `hist[W-1:0]`: newest bit in `hist[0]`.
  - `fill`: bits received since clear, saturating at W.
  - Latched `pat_r`, `len_r`, `ovl_r`.
- Length clamp at load: `len` of 0 or greater than W is stored as W.
- On an `en` cycle:
  - `hist_next = {hist[W-2:0], a}`.
  - `fill_next = min(fill+1, W)`.
  - `match_now = (fill+1 ≥ len_r) && ((hist_next ^ pat_r) & mask) == 0`, where `mask` has its low `len_r` bits set.
- `y_mealy = en & match_now & ~load`. It is purely combinational and must not be registered.
- `y_moore` updates only on `en` cycles, to `match_now`. Between strobes it holds its value.
- `match_count` increments on `en & match_now`. It saturates at all-ones with no wrap.
- Non-overlap mode (`ovl_r = 0`): on a match, `fill` is cleared to 0 instead of taking `fill_next`. `hist` still shifts. The next match therefore needs `len_r` fresh bits.
- Overlap mode: `fill` advances normally, so a match can reuse earlier bits (101 inside 10101 matches twice).
- `load`:
  - Latches the configuration.
  - Clears `hist`, `fill`, `y_moore` and `match_count` to 0.
  - If `en` is high in the same cycle, `load` wins: `a` is discarded and no match is counted.
- Reset values:
  - `hist`, `fill`, `y_moore`, `match_count` are 0.
  - `pat_r = RESET_PATTERN`, `len_r = RESET_LEN`, `ovl_r = 1`.
  - `y_mealy` is 0 while `reset` is high.

## Timing

- Mealy latency: 0 cycles. `y_mealy` is valid in the same cycle as the `en` strobe carrying the last pattern bit.
- Moore latency: 1 cycle. `y_moore` rises on the clock edge that ends that strobe cycle and stays high until the next `en`.
- `match_count` shows the new value 1 cycle after the matching strobe.
- A new configuration takes effect for the first `en` after the `load` cycle.
- Reset asserted mid-stream clears everything on the next edge. Partial matches are lost.
- `en` held high continuously is legal: one bit is consumed per cycle.

## Structure

- Package `seq_detector_pkg`:
  - `localparam` `LEN_W = $clog2(W+1)` helper function.
  - Function `len_mask(len)` returning the W-bit low mask.
  - Default-pattern constants.
- Sub-module `sat_counter` (parameter width; ports `clk`, `reset`, `clear`, `inc`, `cnt`): the saturating match counter.
- Everything else is inline: the history shifter, fill counter and match compare.

## Test plan

- Reset defaults (101, len 3, overlap), stream 1,0,1,0,1 one bit per strobe:
  - `y_mealy` high on strobes 3 and 5.
  - `y_moore` high after strobes 3 and 5.
  - `match_count` = 2.
- Load `overlap=0`, same stream 1,0,1,0,1:
  - Match only on strobe 3; `match_count` = 1.
  - Then 0,1 → match on the 2nd further bit (strobe 7 overall, after `fill` is rebuilt from strobes 5–7), so the next match needs bits 1,0,1 at strobes 5,6,7.
- Load pattern 8'b1111_0000, len 8, stream 1111_0000 → single match on strobe 8. The first 7 strobes give no match even with partial history equal.
- Load len 0 → stored as 8. Load with `en` high in the same cycle → that bit is ignored and `match_count` = 0 afterwards.
- CNT_W = 2, pattern 1 len 1, stream of five 1s → `match_count` reads 1,2,3,3,3.
- Reset asserted after 2 of 3 pattern bits, then the final bit → no match. The next full 1,0,1 matches normally.
